// File: rtl/uart_msg_tx.sv
// Sends a fixed-length message from an external combinational ROM as 8N1 UART frames, LSB first.
// The start/busy/done handshake lets a controller trigger one message and see when it has finished.
//
// state | meaning
// IDLE  | line idle high; waiting for start
// LOAD  | one cycle; latch rom_data[rom_addr] into the shift register
// START | start bit (tx=0) for BAUD_DIV cycles
// DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (tx=1); then next byte, or done
module uart_msg_tx #(
    parameter int BAUD_DIV = 434,
    parameter int MSG_LEN  = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [15:0]       BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;

    wire baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            rom_addr <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            // abort wins over any in-progress activity; a truncated frame is acceptable
            if (abort && state != IDLE) begin
                state    <= IDLE;
                baud_cnt <= 16'd0;
                bit_cnt  <= 3'd0;
                rom_addr <= '0;
                tx       <= 1'b1;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                        if (start && !abort) begin
                            state    <= LOAD;
                            rom_addr <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        shift    <= rom_data;
                        tx       <= 1'b0;
                        baud_cnt <= 16'd0;
                        state    <= START;
                    end
                    START: begin
                        if (baud_end) begin
                            baud_cnt <= 16'd0;
                            bit_cnt  <= 3'd0;
                            tx       <= shift[0];
                            shift    <= shift >> 1;
                            state    <= DATA;
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (baud_end) begin
                            baud_cnt <= 16'd0;
                            if (bit_cnt == 3'd7) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx      <= shift[0];
                                shift   <= shift >> 1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    STOP: begin
                        if (baud_end) begin
                            baud_cnt <= 16'd0;
                            // explicit return to 0 so a full 2**ADDR_W message never relies on overflow
                            if (rom_addr == ADDR_LAST) begin
                                rom_addr <= '0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= LOAD;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
